// File: rtl/n64_pi_address_tracker.sv
// N64 PI cartridge-side address tracker: latches the 32-bit address from the
// multiplexed AD bus and auto-increments it across read/write bursts.
module n64_pi_address_tracker #(
    parameter int ADDRESS_INCREMENT = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_n64_pi_aleh,
    input  logic        i_n64_pi_alel,
    input  logic        i_n64_pi_read,
    input  logic        i_n64_pi_write,
    input  logic [15:0] i_n64_pi_ad,
    output logic [31:0] o_address,
    output logic        o_address_valid,
    output logic        o_read_request,
    output logic        o_write_request,
    output logic [15:0] o_write_data,
    output logic [7:0]  o_word_count,
    output logic        o_busy,
    output logic        o_error
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR_HIGH, S_ADDR_LOW, S_DATA} state_t;

    state_t      r_state, w_state_next;
    logic        r_aleh_q, r_alel_q, r_read_q, r_write_q;
    logic [31:0] r_address;
    logic [15:0] r_write_data;
    logic [7:0]  r_word_count;
    logic        r_address_valid, r_read_request, r_write_request;
    logic        r_error, r_lock, r_wr_pend;

    logic w_aleh_rise, w_aleh_fall, w_alel_fall;
    logic w_read_fall, w_read_rise, w_write_rise, w_both_low;
    logic w_latch_hi, w_latch_lo, w_rd_req, w_wr_req;
    logic w_set_err, w_clr_err;
    logic [1:0] w_steps;

    assign w_aleh_rise  =  i_n64_pi_aleh  & ~r_aleh_q;
    assign w_aleh_fall  = ~i_n64_pi_aleh  &  r_aleh_q;
    assign w_alel_fall  = ~i_n64_pi_alel  &  r_alel_q;
    assign w_read_fall  = ~i_n64_pi_read  &  r_read_q;
    assign w_read_rise  =  i_n64_pi_read  & ~r_read_q;
    assign w_write_rise =  i_n64_pi_write & ~r_write_q;
    assign w_both_low   = ~i_n64_pi_read  & ~i_n64_pi_write;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch_hi   = 1'b0;
        w_latch_lo   = 1'b0;
        w_rd_req     = 1'b0;
        w_wr_req     = 1'b0;
        w_set_err    = 1'b0;
        w_clr_err    = 1'b0;
        w_steps      = 2'd0;
        if (w_aleh_rise) begin
            // A new address phase always wins and discards any pending increment.
            w_state_next = S_ADDR_HIGH;
            w_clr_err    = 1'b1;
        end else begin
            case (r_state)
                S_ADDR_HIGH: begin
                    if (w_aleh_fall) begin
                        w_latch_hi = 1'b1;
                        if (!i_n64_pi_alel) begin
                            w_set_err    = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next = S_ADDR_LOW;
                        end
                    end
                end
                S_ADDR_LOW: begin
                    if (w_alel_fall) begin
                        w_latch_lo   = 1'b1;
                        w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_lock) begin
                        w_steps = 2'd0;
                    end else if (w_both_low) begin
                        w_set_err = 1'b1;
                    end else begin
                        if (w_write_rise)     w_wr_req = 1'b1;
                        else if (w_read_fall) w_rd_req = 1'b1;
                        w_steps = {1'b0, r_wr_pend} + {1'b0, w_read_rise};
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_aleh_q        <= 1'b0;
            r_alel_q        <= 1'b0;
            r_read_q        <= 1'b1;
            r_write_q       <= 1'b1;
            r_address       <= 32'd0;
            r_write_data    <= 16'd0;
            r_word_count    <= 8'd0;
            r_address_valid <= 1'b0;
            r_read_request  <= 1'b0;
            r_write_request <= 1'b0;
            r_error         <= 1'b0;
            r_lock          <= 1'b0;
            r_wr_pend       <= 1'b0;
        end else begin
            r_aleh_q        <= i_n64_pi_aleh;
            r_alel_q        <= i_n64_pi_alel;
            r_read_q        <= i_n64_pi_read;
            r_write_q       <= i_n64_pi_write;
            r_address_valid <= w_latch_lo;
            r_read_request  <= w_rd_req;
            r_write_request <= w_wr_req;
            // Write increments land one cycle late so the request carries the old address.
            r_wr_pend       <= w_wr_req;
            if (w_clr_err) begin
                r_error <= 1'b0;
                r_lock  <= 1'b0;
            end
            if (w_set_err) begin
                r_error <= 1'b1;
                r_lock  <= 1'b1;
            end
            if (w_latch_hi) r_address[31:16] <= i_n64_pi_ad;
            if (w_latch_lo) begin
                r_address[15:0] <= {i_n64_pi_ad[15:1], 1'b0};
                r_word_count    <= 8'd0;
            end
            if (w_steps != 2'd0) begin
                r_address    <= r_address + 32'(w_steps) * 32'(ADDRESS_INCREMENT);
                r_word_count <= r_word_count + {6'd0, w_steps};
            end
            if (w_wr_req) r_write_data <= i_n64_pi_ad;
        end
    end

    assign o_address       = r_address;
    assign o_address_valid = r_address_valid;
    assign o_read_request  = r_read_request;
    assign o_write_request = r_write_request;
    assign o_write_data    = r_write_data;
    assign o_word_count    = r_word_count;
    assign o_busy          = (r_state != S_IDLE);
    assign o_error         = r_error;

endmodule

// File: tb/tb_n64_pi_address_tracker.sv
// Scoreboard bench for n64_pi_address_tracker: expected pulses are queued at
// stimulus time and matched against DUT pulses sampled on the falling edge.
module tb_n64_pi_address_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        aleh, alel, rd_n, wr_n;
    logic [15:0] ad;
    logic [31:0] address;
    logic        address_valid, read_request, write_request, busy, error;
    logic [15:0] write_data;
    logic [7:0]  word_count;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [15:0] data;
    } ev_t;

    localparam logic [1:0] K_VALID = 2'd1, K_READ = 2'd2, K_WRITE = 2'd3;

    ev_t sb_q[$];
    int  n_total = 0;
    int  n_bad   = 0;

    n64_pi_address_tracker #(.ADDRESS_INCREMENT(2)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_n64_pi_aleh   (aleh),
        .i_n64_pi_alel   (alel),
        .i_n64_pi_read   (rd_n),
        .i_n64_pi_write  (wr_n),
        .i_n64_pi_ad     (ad),
        .o_address       (address),
        .o_address_valid (address_valid),
        .o_read_request  (read_request),
        .o_write_request (write_request),
        .o_write_data    (write_data),
        .o_word_count    (word_count),
        .o_busy          (busy),
        .o_error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic latch_addr(input logic [15:0] hi, input logic [15:0] lo);
        aleh = 1'b1; alel = 1'b1;
        step(2);
        ad = hi;
        step(1);
        aleh = 1'b0;
        step(2);
        ad = lo;
        step(1);
        alel = 1'b0;
        push(K_VALID, {hi, lo[15:1], 1'b0}, 16'd0);
        step(2);
    endtask

    task automatic rd_word(input logic [31:0] a);
        rd_n = 1'b0;
        push(K_READ, a, 16'd0);
        step(2);
        rd_n = 1'b1;
        step(2);
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [15:0] d);
        ad   = d;
        wr_n = 1'b0;
        step(2);
        wr_n = 1'b1;
        push(K_WRITE, a, d);
        step(2);
    endtask

    // Pulse monitor: every request/valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (address_valid || read_request || write_request)) begin
            logic [1:0] k;
            ev_t e;
            chk("pulse_excl", 32'(address_valid) + 32'(read_request) + 32'(write_request), 32'd1);
            k = address_valid ? K_VALID : (read_request ? K_READ : K_WRITE);
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, k}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_kind", {30'd0, k}, {30'd0, e.kind});
                chk("pulse_addr", address, e.addr);
                if (k == K_WRITE) chk("pulse_wdata", {16'd0, write_data}, {16'd0, e.data});
            end
        end
    end

    initial begin
        rst = 1'b1; aleh = 1'b0; alel = 1'b0; rd_n = 1'b1; wr_n = 1'b1; ad = 16'd0;
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_addr",  address, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_err",   {31'd0, error}, 32'd0);
        chk("rst_count", {24'd0, word_count}, 32'd0);
        chk("rst_wdata", {16'd0, write_data}, 32'd0);

        latch_addr(16'h1000, 16'h0203);
        chk("latch_addr",  address, 32'h1000_0202);
        chk("latch_count", {24'd0, word_count}, 32'd0);
        chk("latch_busy",  {31'd0, busy}, 32'd1);

        latch_addr(16'h1000, 16'h0000);
        for (int i = 0; i < 4; i++) rd_word(32'h1000_0000 + 32'(2 * i));
        chk("rd_addr",  address, 32'h1000_0008);
        chk("rd_count", {24'd0, word_count}, 32'd4);

        latch_addr(16'h1E00, 16'h0000);
        wr_word(32'h1E00_0000, 16'hCAFE);
        wr_word(32'h1E00_0002, 16'hBEEF);
        chk("wr_addr",  address, 32'h1E00_0004);
        chk("wr_count", {24'd0, word_count}, 32'd2);
        chk("wr_data",  {16'd0, write_data}, 32'h0000_BEEF);

        latch_addr(16'hFFFF, 16'hFFFE);
        rd_word(32'hFFFF_FFFE);
        chk("wrap_addr", address, 32'h0000_0000);
        chk("wrap_err",  {31'd0, error}, 32'd0);

        latch_addr(16'h0000, 16'h0000);
        for (int i = 0; i < 256; i++) rd_word(32'(2 * i));
        chk("cnt_wrap",      {24'd0, word_count}, 32'd0);
        chk("cnt_wrap_addr", address, 32'h0000_0200);

        // ALE_H rise coinciding with a /READ fall must abort without a pulse.
        latch_addr(16'h1000, 16'h0000);
        rd_word(32'h1000_0000);
        rd_word(32'h1000_0002);
        aleh = 1'b1; rd_n = 1'b0;
        step(2);
        rd_n = 1'b1;
        step(2);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        chk("abort_addr", address, 32'h1000_0004);
        rd_n = 1'b0; step(2); rd_n = 1'b1; step(2);
        chk("ah_rd_addr", address, 32'h1000_0004);
        chk("ah_rd_err",  {31'd0, error}, 32'd0);
        aleh = 1'b0;
        step(2);
        chk("alel_low_err",  {31'd0, error}, 32'd1);
        chk("alel_low_busy", {31'd0, busy}, 32'd0);

        latch_addr(16'h1000, 16'h0000);
        rd_n = 1'b0; wr_n = 1'b0; ad = 16'h1234;
        step(2);
        chk("both_err",  {31'd0, error}, 32'd1);
        chk("both_busy", {31'd0, busy}, 32'd1);
        rd_n = 1'b1; wr_n = 1'b1;
        step(2);
        rd_n = 1'b0; step(2); rd_n = 1'b1; step(2);
        chk("lock_addr",  address, 32'h1000_0000);
        chk("lock_count", {24'd0, word_count}, 32'd0);
        chk("lock_wdata", {16'd0, write_data}, 32'h0000_BEEF);
        aleh = 1'b1; alel = 1'b1;
        step(2);
        chk("err_clear", {31'd0, error}, 32'd0);
        latch_addr(16'h2000, 16'h0010);
        chk("relatch_addr", address, 32'h2000_0010);

        rd_n = 1'b0;
        push(K_READ, 32'h2000_0010, 16'd0);
        step(2);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
        rd_n = 1'b1;
        step(3);
        chk("mrst_addr",  address, 32'd0);
        chk("mrst_busy",  {31'd0, busy}, 32'd0);
        chk("mrst_count", {24'd0, word_count}, 32'd0);
        chk("mrst_err",   {31'd0, error}, 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/n64_pi_address_tracker.md
Name: n64_pi_address_tracker

Overview:
- Front end of the N64 PI (parallel interface) bus on the cartridge side: captures the 32-bit bus address from the multiplexed 16-bit AD bus using ALE_H/ALE_L, then auto-increments it over read and write bursts.
- Generates per-word read and write request pulses and write data.
- Its o_address output feeds the bank decoder directly; it is the producer of the addresses that the decoder translates.
- All N64 inputs arrive already synchronized to i_clk.

Parameters:
- ADDRESS_INCREMENT, 2, byte increment applied to o_address after each completed data word (one 16-bit word).

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_n64_pi_aleh  input  1  synchronized ALE_H level, active high.
- i_n64_pi_alel  input  1  synchronized ALE_L level, active high.
- i_n64_pi_read  input  1  synchronized /READ level, active low.
- i_n64_pi_write  input  1  synchronized /WRITE level, active low.
- i_n64_pi_ad  input  16  synchronized AD bus.
- o_address  output  32  current word byte address; bit 0 is always 0.
- o_address_valid  output  1  one-cycle pulse when a new address is fully latched.
- o_read_request  output  1  one-cycle pulse per read word, issued with the current o_address.
- o_write_request  output  1  one-cycle pulse per write word, issued with o_write_data.
- o_write_data  output  16  AD value sampled at the /WRITE rising edge.
- o_word_count  output  8  number of words completed since the last address latch; wraps 255→0.
- o_busy  output  1  high in any state other than IDLE.
- o_error  output  1  sticky protocol-error flag; cleared on the next ALE_H rising edge or on reset.

Behaviour:
- Edge detection: one registered copy of each control input. An edge is the current sample differing from the previous one. Every output reacts on the clock edge that ends the detection cycle, so it is visible 1 cycle after the edge first appears on the inputs.
- Reset: state IDLE, o_address=0, o_write_data=0, o_word_count=0, all pulses 0, o_busy=0, o_error=0. Edge-history registers load their inactive values (aleh=0, alel=0, read=1, write=1).
- States: IDLE, ADDR_HIGH, ADDR_LOW, DATA.
  - Any state: an ALE_H rising edge → ADDR_HIGH and clears o_error. This has highest priority and aborts any burst in progress, with no pulses issued.
  - ADDR_HIGH: on the ALE_H falling edge, o_address[31:16] ← i_n64_pi_ad (sampled at that edge), then → ADDR_LOW. If ALE_L is low at that edge, set o_error and go to IDLE.
  - ADDR_LOW: on the ALE_L falling edge, o_address[15:0] ← {i_n64_pi_ad[15:1], 1'b0}, o_word_count←0, pulse o_address_valid, then → DATA.
  - DATA:
    - /READ falling edge → pulse o_read_request (address unchanged).
    - /READ rising edge → o_address += ADDRESS_INCREMENT, o_word_count += 1.
    - /WRITE rising edge → o_write_data ← AD, pulse o_write_request with the pre-increment o_address. On the following cycle, o_address += ADDRESS_INCREMENT and o_word_count += 1.
  - IDLE: /READ and /WRITE edges are ignored.
- Address arithmetic: modulo 2^32. 0xFFFF_FFFE + 2 → 0x0000_0000, with no flag.
- Protocol errors:
  - /READ and /WRITE both low in the same sample while in DATA: set o_error, suppress all pulses and increments until the next ALE_H rise, and stay in DATA.
  - /READ or /WRITE edges in ADDR_HIGH or ADDR_LOW: ignored, o_error is not set.
- o_read_request, o_write_request and o_address_valid are never high in the same cycle.
- Reset in the middle of a burst returns to the reset values on the next edge. Control lines held low through reset produce no spurious edges after reset, because the history registers are preloaded with inactive values.

Test Plan:
- Address latch: ALE_H/ALE_L rise; AD=0x1000 then ALE_H falls; AD=0x0203 then ALE_L falls → o_address_valid pulses once, o_address=0x10000202, o_word_count=0, o_busy=1.
- Read burst: after latching 0x10000000, four /READ low-high pulses → 4 o_read_request pulses at addresses 0x10000000, 0x10000002, 0x10000004, 0x10000006; final o_address=0x10000008, o_word_count=4.
- Write burst: latch 0x1E000000, write AD=0xCAFE then 0xBEEF → o_write_request pulses carrying (0x1E000000, 0xCAFE) and (0x1E000002, 0xBEEF); final o_address=0x1E000004.
- Wrap: latch 0xFFFFFFFE, one read → o_address=0x00000000. Also, 256 reads → o_word_count=0.
- Abort and error:
  - ALE_H rise in the middle of a burst (after 2 reads) → no further pulses, state ADDR_HIGH.
  - /READ and /WRITE low together in DATA → o_error=1, no pulses. o_error clears on the next ALE_H rise.
- Reset: assert i_reset during DATA with /READ held low, release, then raise /READ → all outputs are at reset values and no o_read_request pulse is issued.
